config_sequencer: RTL and testbench

CONFIG_SEQUENCER -- requirements
Module: config_sequencer

---
 rtl/spirose_conf_pkg.sv | 17 +
 rtl/config_sequencer.sv | 100 ++++++++++
 tb/tb_config_sequencer.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spirose_conf_pkg.sv
// Shared definitions for the driver configuration path: config width,
// sequencer state encoding and the power-up default configuration.
package spirose_conf_pkg;

  localparam int CONF_W = 48;

  localparam logic [CONF_W-1:0] DEFAULT_CONF_VALUE = 48'h0000_0000_0000;

  typedef enum logic [2:0] {
    BOOT,
    IDLE,
    WAIT_SYNC,
    WAIT_IDLE,
    PRESENT
  } config_seq_state_t;

endpackage

// File: rtl/config_sequencer.sv
// Configuration sequencer: holds the newest config from the SPI slave in a
// shadow register and hands it to the driver controller at a revolution
// boundary (or after a sync timeout), once the driver is between column loads.
module config_sequencer
  import spirose_conf_pkg::*;
#(
  parameter logic [CONF_W-1:0] DEFAULT_CONF = DEFAULT_CONF_VALUE,
  parameter int unsigned       SYNC_TIMEOUT = 33_000_000
) (
  input  logic              clk_33,
  input  logic              rst,
  input  logic [CONF_W-1:0] config_in,
  input  logic              new_config_available,
  input  logic              position_sync,
  input  logic              driver_idle,
  input  logic              conf_ack,
  output logic [CONF_W-1:0] conf_out,
  output logic              conf_valid,
  output logic              pending,
  output logic [7:0]        overwrite_count,
  output logic [7:0]        timeout_count
);

  config_seq_state_t state;
  logic [CONF_W-1:0] shadow;
  logic [31:0]       sync_count;
  logic              transfer;

  // Cycle in which the shadow moves into conf_out.
  assign transfer = (state == WAIT_IDLE) && driver_idle;

  // Sequencer state, shadow capture and saturating statistics counters.
  always_ff @(posedge clk_33) begin
    if (rst) begin
      state           <= BOOT;
      conf_out        <= '0;
      conf_valid      <= 1'b0;
      pending         <= 1'b0;
      shadow          <= '0;
      sync_count      <= '0;
      overwrite_count <= '0;
      timeout_count   <= '0;
    end else begin
      // A strobe always lands in the shadow; it only counts as an overwrite
      // when it displaces a value that is not leaving this same cycle.
      if (new_config_available) begin
        shadow  <= config_in;
        pending <= 1'b1;
        if (pending && !transfer && (overwrite_count != 8'hFF)) begin
          overwrite_count <= overwrite_count + 8'd1;
        end
      end else if (transfer) begin
        pending <= 1'b0;
      end

      case (state)
        BOOT: begin
          conf_out   <= DEFAULT_CONF;
          conf_valid <= 1'b1;
          state      <= PRESENT;
        end
        IDLE: begin
          if (pending) begin
            sync_count <= '0;
            state      <= WAIT_SYNC;
          end
        end
        WAIT_SYNC: begin
          if (position_sync) begin
            state <= WAIT_IDLE;
          end else if (sync_count == 32'(SYNC_TIMEOUT - 1)) begin
            state <= WAIT_IDLE;
            if (timeout_count != 8'hFF) begin
              timeout_count <= timeout_count + 8'd1;
            end
          end else begin
            sync_count <= sync_count + 32'd1;
          end
        end
        WAIT_IDLE: begin
          if (driver_idle) begin
            conf_out   <= shadow;
            conf_valid <= 1'b1;
            state      <= PRESENT;
          end
        end
        PRESENT: begin
          if (conf_ack) begin
            conf_valid <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_config_sequencer.sv
// Self-checking bench for config_sequencer. Expected values come from a
// transaction-level view: the last strobed value wins, extra strobes before a
// hand-off add to a saturating overwrite tally, and hand-off timing is
// counted in whole cycles from the sync pulse or from pending rising.
module tb_config_sequencer;
  import spirose_conf_pkg::*;

  localparam logic [CONF_W-1:0] TB_DEFAULT = 48'hDEAD_BEEF_0001;
  localparam int unsigned       TB_TIMEOUT = 100;

  logic              clk_33 = 1'b0;
  logic              rst = 1'b1;
  logic [CONF_W-1:0] config_in = '0;
  logic              new_config_available = 1'b0;
  logic              position_sync = 1'b0;
  logic              driver_idle = 1'b1;
  logic              conf_ack = 1'b0;
  logic [CONF_W-1:0] conf_out;
  logic              conf_valid;
  logic              pending;
  logic [7:0]        overwrite_count;
  logic [7:0]        timeout_count;

  int checks = 0;
  int errors = 0;
  int exp_ov = 0;
  int exp_to = 0;

  config_sequencer #(
    .DEFAULT_CONF(TB_DEFAULT),
    .SYNC_TIMEOUT(TB_TIMEOUT)
  ) dut (
    .clk_33(clk_33),
    .rst(rst),
    .config_in(config_in),
    .new_config_available(new_config_available),
    .position_sync(position_sync),
    .driver_idle(driver_idle),
    .conf_ack(conf_ack),
    .conf_out(conf_out),
    .conf_valid(conf_valid),
    .pending(pending),
    .overwrite_count(overwrite_count),
    .timeout_count(timeout_count)
  );

  // Free-running 100 MHz-style clock; inputs change and outputs are read at negedge.
  always #5 clk_33 = ~clk_33;

  function automatic int sat8(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic logic [CONF_W-1:0] rand48();
    logic [31:0] a;
    logic [31:0] b;
    a = $urandom;
    b = $urandom;
    return {a[15:0], b};
  endfunction

  task automatic step();
    @(negedge clk_33);
  endtask

  task automatic strobe(input logic [CONF_W-1:0] v);
    config_in = v;
    new_config_available = 1'b1;
    step();
    new_config_available = 1'b0;
    config_in = rand48();
  endtask

  task automatic sync_pulse();
    position_sync = 1'b1;
    step();
    position_sync = 1'b0;
  endtask

  task automatic do_ack();
    conf_ack = 1'b1;
    step();
    conf_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    config_in = rand48();
    new_config_available = 1'b1;
    step();
    step();
    new_config_available = 1'b0;
    checks++; if (conf_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b expected 0", conf_valid); end
    checks++; if (conf_out !== '0) begin errors++; $display("[TB] FAIL reset_out got %h expected 0", conf_out); end
    checks++; if (pending !== 1'b0) begin errors++; $display("[TB] FAIL reset_pending got %b expected 0", pending); end
    checks++; if (overwrite_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_ovc got %0d expected 0", overwrite_count); end
    checks++; if (timeout_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_toc got %0d expected 0", timeout_count); end
    rst = 1'b0;
    step();
    checks++; if (conf_valid !== 1'b1) begin errors++; $display("[TB] FAIL boot_valid got %b expected 1", conf_valid); end
    checks++; if (conf_out !== TB_DEFAULT) begin errors++; $display("[TB] FAIL boot_out got %h expected %h", conf_out, TB_DEFAULT); end
    checks++; if (pending !== 1'b0) begin errors++; $display("[TB] FAIL boot_pending got %b expected 0", pending); end
    step();
    checks++; if (conf_valid !== 1'b1) begin errors++; $display("[TB] FAIL boot_hold got %b expected 1", conf_valid); end
    do_ack();
    checks++; if (conf_valid !== 1'b0) begin errors++; $display("[TB] FAIL boot_ack got %b expected 0", conf_valid); end
  endtask

  task automatic test_basic();
    logic [CONF_W-1:0] v;
    v = 48'hA5A5_0000_1234;
    driver_idle = 1'b1;
    strobe(v);
    checks++; if (pending !== 1'b1) begin errors++; $display("[TB] FAIL basic_pending got %b expected 1", pending); end
    repeat (9) step();
    sync_pulse();
    checks++; if (conf_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_early got %b expected 0", conf_valid); end
    step();
    checks++; if (conf_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid got %b expected 1", conf_valid); end
    checks++; if (conf_out !== v) begin errors++; $display("[TB] FAIL basic_out got %h expected %h", conf_out, v); end
    checks++; if (pending !== 1'b0) begin errors++; $display("[TB] FAIL basic_clear got %b expected 0", pending); end
    do_ack();
    checks++; if (conf_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_ack got %b expected 0", conf_valid); end
  endtask

  task automatic test_overwrite();
    strobe(48'd1);
    step();
    strobe(48'd2);
    strobe(48'd3);
    exp_ov = sat8(exp_ov + 2);
    repeat (3) step();
    sync_pulse();
    step();
    checks++; if (conf_out !== 48'd3) begin errors++; $display("[TB] FAIL ovw_out got %h expected 3", conf_out); end
    checks++; if (overwrite_count !== 8'(exp_ov)) begin errors++; $display("[TB] FAIL ovw_count got %0d expected %0d", overwrite_count, exp_ov); end
    do_ack();
  endtask

  task automatic test_timeout();
    logic [CONF_W-1:0] v;
    int n;
    v = rand48();
    driver_idle = 1'b1;
    strobe(v);
    n = 0;
    while (!conf_valid && n < 200) begin
      step();
      n++;
    end
    exp_to = sat8(exp_to + 1);
    checks++; if (n != 102) begin errors++; $display("[TB] FAIL tmo_latency got %0d expected 102", n); end
    checks++; if (conf_out !== v) begin errors++; $display("[TB] FAIL tmo_out got %h expected %h", conf_out, v); end
    checks++; if (timeout_count !== 8'(exp_to)) begin errors++; $display("[TB] FAIL tmo_count got %0d expected %0d", timeout_count, exp_to); end
    do_ack();
  endtask

  task automatic test_transfer_strobe();
    logic [CONF_W-1:0] x;
    logic [CONF_W-1:0] y;
    x = rand48();
    y = rand48();
    strobe(x);
    repeat (3) step();
    driver_idle = 1'b0;
    sync_pulse();
    repeat (2) step();
    checks++; if (conf_valid !== 1'b0) begin errors++; $display("[TB] FAIL xfer_wait got %b expected 0", conf_valid); end
    driver_idle = 1'b1;
    strobe(y);
    checks++; if (conf_valid !== 1'b1) begin errors++; $display("[TB] FAIL xfer_valid got %b expected 1", conf_valid); end
    checks++; if (conf_out !== x) begin errors++; $display("[TB] FAIL xfer_out got %h expected %h", conf_out, x); end
    checks++; if (pending !== 1'b1) begin errors++; $display("[TB] FAIL xfer_pending got %b expected 1", pending); end
    checks++; if (overwrite_count !== 8'(exp_ov)) begin errors++; $display("[TB] FAIL xfer_ovc got %0d expected %0d", overwrite_count, exp_ov); end
    do_ack();
    repeat (2) step();
    sync_pulse();
    step();
    checks++; if (conf_out !== y) begin errors++; $display("[TB] FAIL xfer_next got %h expected %h", conf_out, y); end
    checks++; if (overwrite_count !== 8'(exp_ov)) begin errors++; $display("[TB] FAIL xfer_ovc2 got %0d expected %0d", overwrite_count, exp_ov); end
    do_ack();
  endtask

  task automatic test_present_strobe();
    logic [CONF_W-1:0] p;
    logic [CONF_W-1:0] w;
    p = rand48();
    w = rand48();
    strobe(p);
    repeat (3) step();
    sync_pulse();
    step();
    strobe(w);
    checks++; if (conf_out !== p) begin errors++; $display("[TB] FAIL pres_hold got %h expected %h", conf_out, p); end
    checks++; if (conf_valid !== 1'b1) begin errors++; $display("[TB] FAIL pres_valid got %b expected 1", conf_valid); end
    checks++; if (pending !== 1'b1) begin errors++; $display("[TB] FAIL pres_pending got %b expected 1", pending); end
    do_ack();
    repeat (2) step();
    sync_pulse();
    step();
    checks++; if (conf_out !== w) begin errors++; $display("[TB] FAIL pres_next got %h expected %h", conf_out, w); end
    checks++; if (overwrite_count !== 8'(exp_ov)) begin errors++; $display("[TB] FAIL pres_ovc got %0d expected %0d", overwrite_count, exp_ov); end
    do_ack();
  endtask

  task automatic test_random();
    logic [CONF_W-1:0] q[$];
    int k;
    int d;
    for (int it = 0; it < 20; it++) begin
      k = $urandom_range(1, 4);
      for (int j = 0; j < k; j++) begin
        q.push_back(rand48());
        strobe(q[$]);
        for (int g = 0; g < int'($urandom_range(2, 5)); g++) begin
          conf_ack = 1'($urandom_range(0, 1));
          step();
        end
        conf_ack = 1'b0;
      end
      exp_ov = sat8(exp_ov + k - 1);
      d = $urandom_range(0, 3);
      driver_idle = (d == 0);
      sync_pulse();
      checks++; if (conf_valid !== 1'b0) begin errors++; $display("[TB] FAIL rnd_early it%0d got %b expected 0", it, conf_valid); end
      repeat (d) step();
      checks++; if (conf_valid !== 1'b0) begin errors++; $display("[TB] FAIL rnd_busy it%0d got %b expected 0", it, conf_valid); end
      driver_idle = 1'b1;
      step();
      checks++; if (conf_valid !== 1'b1) begin errors++; $display("[TB] FAIL rnd_valid it%0d got %b expected 1", it, conf_valid); end
      checks++; if (conf_out !== q[$]) begin errors++; $display("[TB] FAIL rnd_out it%0d got %h expected %h", it, conf_out, q[$]); end
      checks++; if (overwrite_count !== 8'(exp_ov)) begin errors++; $display("[TB] FAIL rnd_ovc it%0d got %0d expected %0d", it, overwrite_count, exp_ov); end
      do_ack();
      q.delete();
    end
  endtask

  task automatic test_saturation();
    logic [CONF_W-1:0] last;
    strobe(rand48());
    repeat (2) step();
    driver_idle = 1'b0;
    sync_pulse();
    last = '0;
    for (int i = 0; i < 300; i++) begin
      last = rand48();
      strobe(last);
    end
    exp_ov = sat8(exp_ov + 300);
    driver_idle = 1'b1;
    step();
    checks++; if (overwrite_count !== 8'(exp_ov)) begin errors++; $display("[TB] FAIL sat_ovc got %0d expected %0d", overwrite_count, exp_ov); end
    checks++; if (conf_out !== last) begin errors++; $display("[TB] FAIL sat_out got %h expected %h", conf_out, last); end
    do_ack();
  endtask

  task automatic test_reset_midop();
    strobe(rand48());
    repeat (2) step();
    driver_idle = 1'b0;
    sync_pulse();
    repeat (3) step();
    rst = 1'b1;
    step();
    exp_ov = 0;
    exp_to = 0;
    checks++; if (pending !== 1'b0) begin errors++; $display("[TB] FAIL mid_pending got %b expected 0", pending); end
    checks++; if (overwrite_count !== 8'(exp_ov)) begin errors++; $display("[TB] FAIL mid_ovc got %0d expected 0", overwrite_count); end
    checks++; if (timeout_count !== 8'(exp_to)) begin errors++; $display("[TB] FAIL mid_toc got %0d expected 0", timeout_count); end
    checks++; if (conf_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_valid got %b expected 0", conf_valid); end
    rst = 1'b0;
    step();
    checks++; if (conf_valid !== 1'b1) begin errors++; $display("[TB] FAIL mid_boot_valid got %b expected 1", conf_valid); end
    checks++; if (conf_out !== TB_DEFAULT) begin errors++; $display("[TB] FAIL mid_boot_out got %h expected %h", conf_out, TB_DEFAULT); end
    driver_idle = 1'b1;
    do_ack();
    checks++; if (conf_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_ack got %b expected 0", conf_valid); end
  endtask

  // Scenario sequence followed by the one summary line.
  initial begin
    test_reset();
    test_basic();
    test_overwrite();
    test_timeout();
    test_transfer_strobe();
    test_present_strobe();
    test_random();
    test_saturation();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
